// File: rtl/core_pixel_agen.sv
// ----------------------------------------------------------------------------
// core_pixel_agen
//   Per-tile address sequencer for the rotate core. For each square tile it
//   walks three phases:
//     FILL   - beat-aligned write addresses into the input tile buffer
//     ROTATE - per-pixel source/destination byte addresses (0/90/180/270, CW/CCW)
//     DRAIN  - beat-aligned read addresses out of the output tile buffer
//
// Build option:
//   CORE_PIXEL_AGEN_MIRROR_EN - adds I_PA_MIRROR (latched at START); when set,
//                               the column index is flipped before rotation.
//
// Ports:
//   I_PA_HCLK, I_PA_HRESET_N     clock, asynchronous active-low reset
//   I_PA_START / I_PA_STOP       start job (IDLE only) / synchronous abort
//   I_PA_DEGREES, I_PA_DIRECTION rotation mode, latched at START
//   I_PA_LAST_TILE               sampled on the final DRAIN beat
//   I_PA_IN_BEAT, I_PA_ROT_READY, I_PA_OUT_BEAT   per-phase advance strobes
//   O_PA_IN_WADDR, O_PA_OUT_RADDR                 buffer beat addresses
//   O_PA_ROT_SRC_ADDR, O_PA_ROT_DST_ADDR, O_PA_ROT_VALID   pixel move pair
//   O_PA_STATE, O_PA_BUSY, O_PA_TILE_DONE         status
// ----------------------------------------------------------------------------
module core_pixel_agen #(
    parameter int unsigned TILE_LOG2  = 3,
    parameter int unsigned BPP        = 3,
    parameter int unsigned BEAT_BYTES = 4,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              I_PA_HCLK,
    input  logic              I_PA_HRESET_N,
    input  logic              I_PA_START,
    input  logic              I_PA_STOP,
    input  logic [1:0]        I_PA_DEGREES,
    input  logic              I_PA_DIRECTION,
    input  logic              I_PA_LAST_TILE,
    input  logic              I_PA_IN_BEAT,
    input  logic              I_PA_ROT_READY,
    input  logic              I_PA_OUT_BEAT,
    output logic [ADDR_W-1:0] O_PA_IN_WADDR,
    output logic [ADDR_W-1:0] O_PA_ROT_SRC_ADDR,
    output logic [ADDR_W-1:0] O_PA_ROT_DST_ADDR,
    output logic              O_PA_ROT_VALID,
    output logic [ADDR_W-1:0] O_PA_OUT_RADDR,
    output logic [1:0]        O_PA_STATE,
    output logic              O_PA_BUSY,
    output logic              O_PA_TILE_DONE
`ifdef CORE_PIXEL_AGEN_MIRROR_EN
    ,
    input  logic              I_PA_MIRROR
`endif
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFill   = 2'd1,
        StRotate = 2'd2,
        StDrain  = 2'd3
    } state_e;

    localparam int unsigned       PIX_W          = 2 * TILE_LOG2;
    localparam int unsigned       NPIX           = 1 << PIX_W;
    localparam int unsigned       BEATS          = NPIX * BPP / BEAT_BYTES;
    localparam logic [ADDR_W-1:0] LAST_BEAT_ADDR = ADDR_W'((BEATS - 1) * BEAT_BYTES);
    localparam logic [ADDR_W-1:0] BEAT_INC       = ADDR_W'(BEAT_BYTES);
    localparam logic [ADDR_W-1:0] BPP_W          = ADDR_W'(BPP);

    state_e                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_in_waddr, w_in_waddr_nxt;
    logic [ADDR_W-1:0]     r_out_raddr, w_out_raddr_nxt;
    logic [PIX_W-1:0]      r_pix, w_pix_nxt;
    logic [1:0]            r_deg, w_deg_nxt;
    logic                  r_dir, w_dir_nxt;
    logic                  r_mirror, w_mirror_nxt;
    logic                  r_tile_done, w_tile_done_nxt;
    logic                  w_mirror_in;

`ifdef CORE_PIXEL_AGEN_MIRROR_EN
    assign w_mirror_in = I_PA_MIRROR;
`else
    assign w_mirror_in = 1'b0;
`endif

    always_ff @(posedge I_PA_HCLK or negedge I_PA_HRESET_N) begin
        if (!I_PA_HRESET_N) begin
            r_state     <= StIdle;
            r_in_waddr  <= '0;
            r_out_raddr <= '0;
            r_pix       <= '0;
            r_deg       <= '0;
            r_dir       <= 1'b0;
            r_mirror    <= 1'b0;
            r_tile_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_waddr  <= w_in_waddr_nxt;
            r_out_raddr <= w_out_raddr_nxt;
            r_pix       <= w_pix_nxt;
            r_deg       <= w_deg_nxt;
            r_dir       <= w_dir_nxt;
            r_mirror    <= w_mirror_nxt;
            r_tile_done <= w_tile_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_in_waddr_nxt  = r_in_waddr;
        w_out_raddr_nxt = r_out_raddr;
        w_pix_nxt       = r_pix;
        w_deg_nxt       = r_deg;
        w_dir_nxt       = r_dir;
        w_mirror_nxt    = r_mirror;
        w_tile_done_nxt = 1'b0;

        if (I_PA_STOP) begin
            w_state_nxt     = StIdle;
            w_in_waddr_nxt  = '0;
            w_out_raddr_nxt = '0;
            w_pix_nxt       = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (I_PA_START) begin
                        w_state_nxt  = StFill;
                        w_deg_nxt    = I_PA_DEGREES;
                        w_dir_nxt    = I_PA_DIRECTION;
                        w_mirror_nxt = w_mirror_in;
                    end
                end
                StFill: begin
                    if (I_PA_IN_BEAT) begin
                        if (r_in_waddr == LAST_BEAT_ADDR) begin
                            w_in_waddr_nxt = '0;
                            w_state_nxt    = StRotate;
                        end else begin
                            w_in_waddr_nxt = r_in_waddr + BEAT_INC;
                        end
                    end
                end
                StRotate: begin
                    if (I_PA_ROT_READY) begin
                        if (r_pix == '1) begin
                            w_pix_nxt   = '0;
                            w_state_nxt = StDrain;
                        end else begin
                            w_pix_nxt = r_pix + PIX_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (I_PA_OUT_BEAT) begin
                        if (r_out_raddr == LAST_BEAT_ADDR) begin
                            w_out_raddr_nxt = '0;
                            w_tile_done_nxt = 1'b1;
                            w_state_nxt     = I_PA_LAST_TILE ? StIdle : StFill;
                        end else begin
                            w_out_raddr_nxt = r_out_raddr + BEAT_INC;
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Rotation mapping on the (row, col) split of the pixel counter. With N a power
    // of two, N-1-x is simply the bitwise inverse of x.
    logic [TILE_LOG2-1:0] w_row, w_col;
    logic [1:0]           w_eff_deg;
    logic [PIX_W-1:0]     w_q;
    logic                 w_rotating;

    assign w_row      = r_pix[PIX_W-1:TILE_LOG2];
    assign w_col      = r_mirror ? ~r_pix[TILE_LOG2-1:0] : r_pix[TILE_LOG2-1:0];
    // CCW by d equals CW by (4-d) mod 4: swaps 90 and 270, keeps 0 and 180.
    assign w_eff_deg  = r_dir ? (2'd0 - r_deg) : r_deg;
    assign w_rotating = (r_state == StRotate);

    always_comb begin
        w_q = '0;
        unique case (w_eff_deg)
            2'd0: w_q = {w_row, w_col};
            2'd1: w_q = {w_col, ~w_row};
            2'd2: w_q = {~w_row, ~w_col};
            2'd3: w_q = {~w_col, w_row};
            default: w_q = '0;
        endcase
    end

    assign O_PA_IN_WADDR     = r_in_waddr;
    assign O_PA_OUT_RADDR    = r_out_raddr;
    // Pair addresses read as zero outside ROTATE so an abort leaves every address at 0.
    assign O_PA_ROT_SRC_ADDR = w_rotating ? ADDR_W'(r_pix) * BPP_W : '0;
    assign O_PA_ROT_DST_ADDR = w_rotating ? ADDR_W'(w_q) * BPP_W : '0;
    assign O_PA_ROT_VALID    = w_rotating;
    assign O_PA_STATE        = r_state;
    assign O_PA_BUSY         = (r_state != StIdle);
    assign O_PA_TILE_DONE    = r_tile_done;

endmodule

// File: tb/tb_core_pixel_agen.sv
module tb_core_pixel_agen;

    localparam int N     = 8;
    localparam int BPP   = 3;
    localparam int BB    = 4;
    localparam int BEATS = 48;
    localparam int NPIX  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, direction = 1'b0, last_tile = 1'b0;
    logic [1:0] degrees = 2'd0;
    logic       in_beat = 1'b0, rot_ready = 1'b0, out_beat = 1'b0, mirror = 1'b0;
    logic [7:0] in_waddr, src_addr, dst_addr, out_raddr;
    logic       rot_valid, busy, tile_done;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int src;
        int dst;
    } pair_t;

    pair_t rot_q[$];
    int    addr_q[$];
    int    spot_p[$];
    int    spot_dst[$];

    always #5 clk = ~clk;

    core_pixel_agen dut (
        .I_PA_HCLK         (clk),
        .I_PA_HRESET_N     (rst_n),
        .I_PA_START        (start),
        .I_PA_STOP         (stop),
        .I_PA_DEGREES      (degrees),
        .I_PA_DIRECTION    (direction),
        .I_PA_LAST_TILE    (last_tile),
        .I_PA_IN_BEAT      (in_beat),
        .I_PA_ROT_READY    (rot_ready),
        .I_PA_OUT_BEAT     (out_beat),
        .O_PA_IN_WADDR     (in_waddr),
        .O_PA_ROT_SRC_ADDR (src_addr),
        .O_PA_ROT_DST_ADDR (dst_addr),
        .O_PA_ROT_VALID    (rot_valid),
        .O_PA_OUT_RADDR    (out_raddr),
        .O_PA_STATE        (state),
        .O_PA_BUSY         (busy),
        .O_PA_TILE_DONE    (tile_done)
`ifdef CORE_PIXEL_AGEN_MIRROR_EN
        ,
        .I_PA_MIRROR       (mirror)
`endif
    );

    // Reference mapping written directly from the row/column formulas.
    function automatic int model_dst(input int p, input int deg, input int dir, input int mir);
        int r, c, ed, q;
        r  = p / N;
        c  = p % N;
        if (mir != 0) c = N - 1 - c;
        ed = (dir != 0) ? (4 - deg) % 4 : deg;
        case (ed)
            0:       q = r * N + c;
            1:       q = c * N + (N - 1 - r);
            2:       q = (N - 1 - r) * N + (N - 1 - c);
            default: q = (N - 1 - c) * N + r;
        endcase
        return q * BPP;
    endfunction

    task automatic start_job(input int deg, input int dir, input int mir);
        @(negedge clk);
        start = 1'b1; degrees = deg[1:0]; direction = dir[0]; mirror = mir[0];
        @(negedge clk);
        // Scramble mode inputs to prove the values were latched.
        start = 1'b0; degrees = ~deg[1:0]; direction = ~dir[0]; mirror = ~mir[0];
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL start_state: got %0d want 1", state);
        end
    endtask

    task automatic do_fill(input bit start_in_fill);
        int  n = 0;
        int  budget = 0;
        bit  gapped = 1'b0;
        for (int i = 0; i < BEATS; i++) addr_q.push_back(i * BB);
        while (addr_q.size() > 0 && budget < 400) begin
            @(negedge clk);
            budget++;
            checks++;
            if (in_waddr !== addr_q[0]) begin
                errors++; $display("FAIL fill_addr: got %0d want %0d", in_waddr, addr_q[0]);
            end
            checks++;
            if (state !== 2'd1) begin
                errors++; $display("FAIL fill_state: got %0d want 1", state);
            end
            if ((n % 7) == 3 && !gapped) begin
                in_beat = 1'b0; start = start_in_fill; gapped = 1'b1;
            end else begin
                in_beat = 1'b1; start = 1'b0; gapped = 1'b0;
                void'(addr_q.pop_front());
                n++;
            end
        end
        @(negedge clk);
        in_beat = 1'b0; start = 1'b0;
        checks++;
        if (addr_q.size() != 0) begin
            errors++; $display("FAIL fill_timeout: got %0d left want 0", addr_q.size());
            addr_q.delete();
        end
        checks++;
        if (state !== 2'd2 || in_waddr !== 8'd0 || rot_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_end: got state=%0d addr=%0d valid=%0b want 2/0/1",
                     state, in_waddr, rot_valid);
        end
    endtask

    task automatic do_rotate(input int deg, input int dir, input int mir,
                             input int stall_p, input int stop_p);
        int p = 0;
        int stalls = 0;
        int budget = 0;
        bit stopped = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            pair_t e;
            e.src = i * BPP;
            e.dst = model_dst(i, deg, dir, mir);
            rot_q.push_back(e);
        end
        while (rot_q.size() > 0 && budget < 400) begin
            @(negedge clk);
            budget++;
            checks++;
            if (rot_valid !== 1'b1 || state !== 2'd2) begin
                errors++; $display("FAIL rot_valid: got valid=%0b state=%0d want 1/2",
                                   rot_valid, state);
            end
            checks++;
            if (src_addr !== rot_q[0].src) begin
                errors++; $display("FAIL rot_src p=%0d: got %0d want %0d", p, src_addr,
                                   rot_q[0].src);
            end
            checks++;
            if (dst_addr !== rot_q[0].dst) begin
                errors++; $display("FAIL rot_dst p=%0d: got %0d want %0d", p, dst_addr,
                                   rot_q[0].dst);
            end
            foreach (spot_p[i]) begin
                if (spot_p[i] == p) begin
                    checks++;
                    if (dst_addr !== spot_dst[i]) begin
                        errors++; $display("FAIL rot_spot p=%0d: got %0d want %0d", p,
                                           dst_addr, spot_dst[i]);
                    end
                end
            end
            if (p == stall_p && stalls < 5) begin
                rot_ready = 1'b0; stalls++;
            end else if (p == stop_p) begin
                stop = 1'b1; rot_ready = 1'b1; stopped = 1'b1;
                rot_q.delete();
            end else begin
                rot_ready = 1'b1;
                void'(rot_q.pop_front());
                p++;
            end
        end
        @(negedge clk);
        rot_ready = 1'b0; stop = 1'b0;
        checks++;
        if (rot_q.size() != 0) begin
            errors++; $display("FAIL rot_timeout: got %0d left want 0", rot_q.size());
            rot_q.delete();
        end
        if (stopped) begin
            checks++;
            if (state !== 2'd0 || busy !== 1'b0 || rot_valid !== 1'b0 || tile_done !== 1'b0) begin
                errors++; $display("FAIL stop_status: got state=%0d busy=%0b valid=%0b done=%0b want 0/0/0/0",
                                   state, busy, rot_valid, tile_done);
            end
            checks++;
            if (src_addr !== 8'd0 || dst_addr !== 8'd0 || in_waddr !== 8'd0 ||
                out_raddr !== 8'd0) begin
                errors++; $display("FAIL stop_addrs: got %0d/%0d/%0d/%0d want 0/0/0/0",
                                   src_addr, dst_addr, in_waddr, out_raddr);
            end
            @(negedge clk);
            checks++;
            if (tile_done !== 1'b0 || state !== 2'd0) begin
                errors++; $display("FAIL stop_after: got done=%0b state=%0d want 0/0",
                                   tile_done, state);
            end
        end else begin
            checks++;
            if (state !== 2'd3 || rot_valid !== 1'b0) begin
                errors++; $display("FAIL rot_end: got state=%0d valid=%0b want 3/0",
                                   state, rot_valid);
            end
        end
    endtask

    task automatic do_drain(input bit last);
        int n = 0;
        int budget = 0;
        bit gapped = 1'b0;
        for (int i = 0; i < BEATS; i++) addr_q.push_back(i * BB);
        while (addr_q.size() > 0 && budget < 400) begin
            @(negedge clk);
            budget++;
            checks++;
            if (out_raddr !== addr_q[0]) begin
                errors++; $display("FAIL drain_addr: got %0d want %0d", out_raddr, addr_q[0]);
            end
            checks++;
            if (state !== 2'd3 || tile_done !== 1'b0) begin
                errors++; $display("FAIL drain_state: got state=%0d done=%0b want 3/0",
                                   state, tile_done);
            end
            if ((n % 5) == 2 && !gapped) begin
                out_beat = 1'b0; gapped = 1'b1;
            end else begin
                out_beat  = 1'b1; gapped = 1'b0;
                last_tile = (addr_q.size() == 1) ? last : ~last;
                void'(addr_q.pop_front());
                n++;
            end
        end
        @(negedge clk);
        out_beat = 1'b0; last_tile = 1'b0;
        checks++;
        if (addr_q.size() != 0) begin
            errors++; $display("FAIL drain_timeout: got %0d left want 0", addr_q.size());
            addr_q.delete();
        end
        checks++;
        if (tile_done !== 1'b1 || state !== (last ? 2'd0 : 2'd1) || out_raddr !== 8'd0 ||
            busy !== !last) begin
            errors++; $display("FAIL drain_end: got done=%0b state=%0d addr=%0d busy=%0b want 1/%0d/0/%0b",
                               tile_done, state, out_raddr, busy, last ? 0 : 1, !last);
        end
        @(negedge clk);
        checks++;
        if (tile_done !== 1'b0) begin
            errors++; $display("FAIL done_pulse: got %0b want 0", tile_done);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (state !== 2'd0 || busy !== 1'b0 || rot_valid !== 1'b0 || tile_done !== 1'b0 ||
            in_waddr !== 8'd0 || out_raddr !== 8'd0 || src_addr !== 8'd0 || dst_addr !== 8'd0) begin
            errors++; $display("FAIL reset_init: got state=%0d busy=%0b addr=%0d want all 0",
                               state, busy, in_waddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_job(1, 0, 0);
        repeat (5) begin
            @(negedge clk);
            in_beat = 1'b1;
        end
        @(negedge clk);
        in_beat = 1'b0;
        checks++;
        if (in_waddr !== 8'd20) begin
            errors++; $display("FAIL reset_prefill: got %0d want 20", in_waddr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || busy !== 1'b0 || in_waddr !== 8'd0 || rot_valid !== 1'b0 ||
            src_addr !== 8'd0 || dst_addr !== 8'd0 || out_raddr !== 8'd0 || tile_done !== 1'b0) begin
            errors++; $display("FAIL reset_async: got state=%0d busy=%0b addr=%0d want 0/0/0",
                               state, busy, in_waddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        start_job(0, 0, 0);
        do_fill(1'b1);
        do_rotate(0, 0, 0, 10, -1);
        do_drain(1'b0);
        do_fill(1'b0);
        do_rotate(0, 0, 0, -1, -1);
        do_drain(1'b1);
    endtask

    task automatic test_cw90_180();
        spot_p   = '{0, 1, 8, 63};
        spot_dst = '{21, 45, 18, 168};
        start_job(1, 0, 0);
        do_fill(1'b0);
        do_rotate(1, 0, 0, -1, -1);
        do_drain(1'b1);
        spot_p   = '{0};
        spot_dst = '{189};
        start_job(2, 0, 0);
        do_fill(1'b0);
        do_rotate(2, 0, 0, -1, -1);
        do_drain(1'b1);
    endtask

    task automatic test_ccw90_cw270();
        spot_p   = '{0, 1};
        spot_dst = '{168, 144};
        start_job(1, 1, 0);
        do_fill(1'b0);
        do_rotate(1, 1, 0, -1, -1);
        do_drain(1'b1);
        start_job(3, 0, 0);
        do_fill(1'b0);
        do_rotate(3, 0, 0, -1, -1);
        do_drain(1'b1);
        spot_p.delete();
        spot_dst.delete();
    endtask

    task automatic test_stop();
        start_job(1, 0, 0);
        do_fill(1'b0);
        do_rotate(1, 0, 0, -1, 20);
    endtask

    task automatic test_mirror();
`ifdef CORE_PIXEL_AGEN_MIRROR_EN
        spot_p   = '{0, 7};
        spot_dst = '{21, 0};
        start_job(0, 0, 1);
        do_fill(1'b0);
        do_rotate(0, 0, 1, -1, -1);
        do_drain(1'b1);
        spot_p.delete();
        spot_dst.delete();
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_cw90_180();
        test_ccw90_cw270();
        test_stop();
        test_mirror();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
